// File: rtl/waveform_sample_gen.sv
// Tone sample generator: steps an 8-bit phase on each edge-detected divided-clock tick and
// emits amplitude-scaled square/saw/triangle samples. Optional PWM output via WAVEFORM_PWM_OUT_EN.
module waveform_sample_gen #(
  parameter int PHASE_W  = 8,
  parameter int SAMPLE_W = 8
) (
  input  logic                Clk_in,
  input  logic                Rst_n,
  input  logic                tick_clk,
  input  logic                enable,
  input  logic [1:0]          wave_sel,
  input  logic [1:0]          amp_sel,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                period_start
`ifdef WAVEFORM_PWM_OUT_EN
  ,
  output logic                pwm_out
`endif
);

  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(128);

  // [0],[1] synchronize tick_clk; [2] delays the synchronized level for rise detection
  logic [2:0]          tick_pipe;
  logic                step;
  logic [PHASE_W-1:0]  phase;
  logic [1:0]          act_wave, act_amp;
  logic [1:0]          wave_eff, amp_eff;
  logic                at_zero;
  logic [SAMPLE_W-1:0] raw, scaled;

  assign step    = tick_pipe[1] & ~tick_pipe[2];
  assign at_zero = (phase == '0);

  // the phase-0 sample already uses the selection being captured on that step
  assign wave_eff = at_zero ? wave_sel : act_wave;
  assign amp_eff  = at_zero ? amp_sel  : act_amp;

  always_comb begin
    raw = '0;
    case (wave_eff)
      2'd0: raw = phase[7] ? 8'd0 : 8'd255;
      2'd1: raw = phase;
      2'd2: raw = phase[7] ? {~phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      2'd3: raw = ~phase;
      default: raw = '0;
    endcase
    scaled = (raw >> amp_eff) + (MID - (MID >> amp_eff));
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      tick_pipe <= '0;
    end else begin
      tick_pipe <= {tick_pipe[1:0], tick_clk};
    end
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      phase        <= '0;
      sample       <= MID;
      sample_valid <= 1'b0;
      period_start <= 1'b0;
      act_wave     <= '0;
      act_amp      <= '0;
    end else if (!enable) begin
      phase        <= '0;
      sample       <= MID;
      sample_valid <= 1'b0;
      period_start <= 1'b0;
    end else begin
      sample_valid <= step;
      period_start <= step & at_zero;
      if (step) begin
        sample <= scaled;
        phase  <= phase + 1'b1;
        if (at_zero) begin
          act_wave <= wave_sel;
          act_amp  <= amp_sel;
        end
      end
    end
  end

`ifdef WAVEFORM_PWM_OUT_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < sample);
    end
  end
`endif

endmodule

// File: doc/waveform_sample_gen.md
Name: waveform_sample_gen

Overview:
- Consumes the divided sample clock, which runs at 256x the output tone frequency (500 Hz to 10 kHz tones).
- Steps an 8-bit phase index once per sample-clock rising edge and emits one 8-bit waveform sample per step to the DAC stage.
- Supports four selectable waveforms and four amplitude levels.
- Runs entirely in the system Clk_in domain; the divided clock is treated as an asynchronous input and edge-detected.

Parameters:
- PHASE_W, 8, phase index width; fixes 256 samples per waveform period. Only 8 is supported.
- SAMPLE_W, 8, output sample width. Only 8 is supported.

Ports:
- Clk_in  input  1  system clock.
- Rst_n  input  1  asynchronous active-low reset.
- tick_clk  input  1  divided sample clock from the clock divider; asynchronous to Clk_in.
- enable  input  1  1 = generate samples, 0 = idle at midscale.
- wave_sel  input  2  waveform select: 0 square, 1 saw up, 2 triangle, 3 saw down.
- amp_sel  input  2  attenuation select: output scaled by 2^-amp_sel.
- sample  output  8  current waveform sample (unsigned, midscale = 128).
- sample_valid  output  1  one-Clk_in pulse when sample updates.
- period_start  output  1  one-Clk_in pulse coincident with sample_valid when phase 0 is emitted.

Behaviour:
- Reset (async, Rst_n=0):
  - phase = 0, sample = 8'd128, sample_valid = 0, period_start = 0.
  - active wave/amp registers = 0; synchronizer and edge flops = 0.
  - Reset is honoured mid-period with no partial sample emitted.
- Tick detection:
  - 2-flop synchronizer on tick_clk, plus one delay flop.
  - step = sync2 & ~dly.
  - Latency: sample_valid is high on the 3rd Clk_in rising edge after the first edge that samples tick_clk = 1.
  - A tick_clk held high yields exactly one step.
  - tick_clk must stay high and low for at least 2 Clk_in cycles each. Faster ticks are unsupported and may be dropped.
- On step with enable=1:
  - sample <= f(phase, wave, amp); phase <= phase + 1, wrapping 255 -> 0.
  - sample_valid = 1 for that one cycle.
  - period_start = 1 when the emitted phase = 0.
- Selection latching:
  - wave_sel and amp_sel are captured into the active registers only on a step where phase = 0.
  - The phase-0 sample uses the newly captured values.
  - Mid-period changes to wave_sel/amp_sel take effect at the next period start, never mid-period.
- Raw waveform by active wave, with p = phase:
  - 0 square: p < 128 -> 255, else 0.
  - 1 saw up: p.
  - 2 triangle: p < 128 -> 2p (0..254), else 2*(255-p) (254..0).
  - 3 saw down: 255 - p.
- Amplitude:
  - sample = (raw >> a) + (128 - (128 >> a)), with a = active amp.
  - Result is centred on midscale and cannot overflow; maximums are 255 / 191 / 159 / 143 for a = 0..3.
- enable = 0:
  - phase forced to 0 and sample forced to 128.
  - sample_valid and period_start stay 0.
  - Steps are ignored.
- Re-enable: the first step emits phase 0, so period_start pulses on the first sample.

Optional Feature:
- Macro: WAVEFORM_PWM_OUT_EN.
- Defined:
  - Adds output port pwm_out (1 bit) and a free-running 8-bit pwm_cnt on Clk_in.
  - pwm_out is registered: pwm_out <= (pwm_cnt < sample).
  - Reset values: pwm_cnt = 0, pwm_out = 0.
  - sample = 0 gives a constant low output; sample = 255 gives high for 255 of every 256 cycles.
- Undefined: no pwm_out port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset released, enable=1, wave_sel=1, amp_sel=0, 256 ticks -> samples 0,1,...,255 in order; period_start only on the first sample; the 257th sample is 0 with period_start.
- wave_sel=2, amp_sel=0, one full period -> phase 0 gives 0, phase 127 gives 254, phase 128 gives 254, phase 255 gives 0.
- wave_sel=0, amp_sel=1 -> samples 191 for phases 0..127, then 64 for phases 128..255.
- Change wave_sel 1->3 at phase 100 -> samples continue as saw up through phase 255; the next phase-0 sample is 255 (saw down).
- tick_clk held high for 50 Clk_in cycles -> exactly one sample_valid pulse, 3 cycles after the rise; enable=0 mid-period -> sample=128 and no valid pulses; Rst_n pulsed low mid-period -> all outputs immediately at reset values.
- With WAVEFORM_PWM_OUT_EN defined, sample held at 64 -> pwm_out high for 64 of every 256 Clk_in cycles.
